// File: rtl/irq_unit_fifo.sv
// irq_unit_fifo: interrupt event FIFO drained through a config-bus register bank.
// Define IRQ_UNIT_FIFO_STATS_EN to add the saturating drop counter at offset 3.
module irq_unit_fifo #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        data_irq_valid,
   input  logic [15:0] data_irq_addr,
   input  logic        cfg_irq_valid,
   input  logic [15:0] cfg_irq_addr,
   input  logic [13:0] config_addr,
   input  logic        config_en,
   input  logic        config_wr,
   input  logic [31:0] config_wdata,
   input  logic        sel,
   output logic [31:0] rdata,
   output logic        error,
   output logic        irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   typedef logic [16:0] entry_t;

   entry_t        mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          overflow;

   logic          access;
   logic [10:0]   off;
   logic          bad;
   logic          rd_ok;
   logic          pop;
   logic          clear;
   logic [CW:0]   free;
   logic          data_ok;
   logic          cfg_ok;
   logic [1:0]    n_push;
   logic [1:0]    n_drop;
   logic          full;
   logic          empty;
   entry_t        head;
   logic [31:0]   status_word;
   logic [31:0]   drops_word;
   logic [31:0]   rdata_d;
   logic          unused_bits;

   assign unused_bits = ^{config_wdata, config_addr[13:11]};

   assign access = sel & config_en;
   assign off    = config_addr[10:0];
   // writes are legal only at CLEAR; anything past offset 3 is unmapped
   assign bad    = access & ((off > 11'd3) | (config_wr & (off != 11'd2)));
   assign rd_ok  = access & ~config_wr & ~bad;
   assign empty  = (count == '0);
   assign full   = (count == DEPTH_W[CW-1:0]);
   assign pop    = rd_ok & (off == 11'd0) & ~empty;
   assign clear  = access & config_wr & (off == 11'd2);
   assign head   = mem[rd_ptr];

   // a same-cycle pop frees one slot for the incoming pushes
   assign free    = DEPTH_W - {1'b0, count} + {{CW{1'b0}}, pop};
   assign data_ok = reset_n & data_irq_valid & (free != '0);
   assign cfg_ok  = reset_n & cfg_irq_valid &
                    (free > {{CW{1'b0}}, data_ok});
   assign n_push  = {1'b0, data_ok} + {1'b0, cfg_ok};
   assign n_drop  = {1'b0, data_irq_valid & ~data_ok} +
                    {1'b0, cfg_irq_valid & ~cfg_ok};

   assign irq = ~empty;

   assign status_word = {overflow, full, empty, 20'b0, 9'(count)};

`ifdef IRQ_UNIT_FIFO_STATS_EN
   logic [CNT_W-1:0] drops;
   logic [CNT_W:0]   drop_sum;

   assign drop_sum   = {1'b0, drops} + (CNT_W + 1)'(n_drop);
   assign drops_word = 32'(drops);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drops <= '0;
      end else if (clear) begin
         drops <= '0;
      end else if (drop_sum[CNT_W]) begin
         drops <= '1;
      end else begin
         drops <= drop_sum[CNT_W-1:0];
      end
   end
`else
   assign drops_word = '0;
`endif

   always_comb begin
      rdata_d = '0;
      if (rd_ok) begin
         unique case (1'b1)
            off == 11'd0: rdata_d = pop ? {1'b1, 14'b0, head} : '0;
            off == 11'd1: rdata_d = status_word;
            off == 11'd3: rdata_d = drops_word;
            default:      rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (data_ok) begin
         mem[wr_ptr] <= {1'b0, data_irq_addr};
      end
      if (cfg_ok) begin
         mem[wr_ptr + AW'(data_ok)] <= {1'b1, cfg_irq_addr};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         rdata    <= '0;
         error    <= 1'b0;
      end else begin
         rd_ptr <= rd_ptr + AW'(pop);
         wr_ptr <= wr_ptr + AW'(n_push);
         count  <= count + CW'(n_push) - CW'(pop);
         rdata  <= rdata_d;
         error  <= bad;
         if (clear) begin
            overflow <= 1'b0;
         end else if (n_drop != 2'd0) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_irq_unit_fifo.sv
// tb_irq_unit_fifo: directed and randomized checks of irq_unit_fifo
// against a queue-based reference model.
module tb_irq_unit_fifo;

   localparam int DEPTH = 16;
   localparam int CNT_W = 8;
   localparam int DMAX  = (1 << CNT_W) - 1;
`ifdef IRQ_UNIT_FIFO_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        data_irq_valid;
   logic [15:0] data_irq_addr;
   logic        cfg_irq_valid;
   logic [15:0] cfg_irq_addr;
   logic [13:0] config_addr;
   logic        config_en;
   logic        config_wr;
   logic [31:0] config_wdata;
   logic        sel;
   logic [31:0] rdata;
   logic        error;
   logic        irq;

   int total = 0;
   int bad = 0;

   logic [16:0] q[$];
   bit          ovf;
   int          drops;

   irq_unit_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .data_irq_valid (data_irq_valid),
      .data_irq_addr  (data_irq_addr),
      .cfg_irq_valid  (cfg_irq_valid),
      .cfg_irq_addr   (cfg_irq_addr),
      .config_addr    (config_addr),
      .config_en      (config_en),
      .config_wr      (config_wr),
      .config_wdata   (config_wdata),
      .sel            (sel),
      .rdata          (rdata),
      .error          (error),
      .irq            (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] status_m();
      int n;
      n = q.size();
      return {ovf, n == DEPTH, n == 0, 20'b0, 9'(n)};
   endfunction

   task automatic push_m(input logic [16:0] e);
      if (q.size() < DEPTH) begin
         q.push_back(e);
      end else begin
         ovf = 1'b1;
         if (drops < DMAX) drops++;
      end
   endtask

   task automatic tick(input string tag);
      bit          acc;
      bit          bd;
      bit          rd;
      bit          clr;
      logic [10:0] off;
      logic [31:0] er;
      acc = sel && config_en;
      off = config_addr[10:0];
      bd  = acc && (off > 11'd3 || (config_wr && off != 11'd2));
      rd  = acc && !config_wr && !bd;
      clr = acc && config_wr && off == 11'd2;
      er  = '0;
      if (rd && off == 11'd1) er = status_m();
      if (rd && off == 11'd3) er = STATS ? 32'(drops) : 32'd0;
      if (rd && off == 11'd0 && q.size() > 0) begin
         er = {1'b1, 14'b0, q[0]};
         q.delete(0);
      end
      if (data_irq_valid) push_m({1'b0, data_irq_addr});
      if (cfg_irq_valid) push_m({1'b1, cfg_irq_addr});
      if (clr) begin
         ovf   = 1'b0;
         drops = 0;
      end
      @(posedge clk);
      #1;
      check({tag, ".rdata"}, rdata, er);
      check({tag, ".err"}, 32'(error), 32'(bd));
      check({tag, ".irq"}, 32'(irq), 32'(q.size() != 0));
   endtask

   task automatic cyc(input string tag, input bit dv, input logic [15:0] da,
                      input bit cv, input logic [15:0] ca, input bit acc,
                      input bit wr, input logic [10:0] off);
      data_irq_valid = dv;
      data_irq_addr  = da;
      cfg_irq_valid  = cv;
      cfg_irq_addr   = ca;
      sel            = acc;
      config_en      = acc;
      config_wr      = wr;
      config_addr    = {3'($urandom), off};
      config_wdata   = $urandom;
      tick(tag);
   endtask

   task automatic rnd(input int n, input int push_pct, input int pop_pct);
      logic [10:0] off;
      for (int i = 0; i < n; i++) begin
         data_irq_valid = ($urandom % 100) < push_pct;
         cfg_irq_valid  = ($urandom % 100) < push_pct;
         data_irq_addr  = 16'($urandom);
         cfg_irq_addr   = 16'($urandom);
         config_wdata   = $urandom;
         if (($urandom % 100) < pop_pct) begin
            sel       = 1'b1;
            config_en = 1'b1;
            config_wr = 1'b0;
            off       = 11'd0;
         end else begin
            sel       = ($urandom % 4) != 0;
            config_en = ($urandom % 4) != 0;
            config_wr = ($urandom % 4) == 0;
            off       = 11'($urandom_range(0, 6));
            if (off == 11'd6) off = 11'($urandom);
         end
         config_addr = {3'($urandom), off};
         tick("rnd");
      end
   endtask

   initial begin
      data_irq_valid = 1'b0;
      data_irq_addr  = '0;
      cfg_irq_valid  = 1'b0;
      cfg_irq_addr   = '0;
      config_addr    = '0;
      config_en      = 1'b0;
      config_wr      = 1'b0;
      config_wdata   = '0;
      sel            = 1'b0;
      ovf            = 1'b0;
      drops          = 0;
      reset_n        = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      check("rst.rdata", rdata, 32'h0);
      check("rst.err", 32'(error), 32'h0);
      check("rst.irq", 32'(irq), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;

      cyc("p30push", 1, 16'h00A5, 0, 0, 0, 0, 0);
      check("p30.irq1", 32'(irq), 32'h1);
      cyc("p30pop", 0, 0, 0, 0, 1, 0, 0);
      check("p30.pop", rdata, 32'h800000A5);
      check("p30.irq0", 32'(irq), 32'h0);
      cyc("p30pop2", 0, 0, 0, 0, 1, 0, 0);
      check("p30.empty", rdata, 32'h0);
      check("p30.noerr", 32'(error), 32'h0);

      cyc("p31push", 1, 16'h0001, 1, 16'h0002, 0, 0, 0);
      cyc("p31pop1", 0, 0, 0, 0, 1, 0, 0);
      check("p31.first", rdata, 32'h80000001);
      cyc("p31pop2", 0, 0, 0, 0, 1, 0, 0);
      check("p31.second", rdata, 32'h80010002);

      for (int i = 0; i < DEPTH + 3; i++) begin
         cyc("p32fill", 1, 16'(i + 16'h100), 0, 0, 0, 0, 0);
      end
      cyc("p32stat", 0, 0, 0, 0, 1, 0, 1);
      check("p32.status", rdata, 32'hC0000010);
      cyc("p32drops", 0, 0, 0, 0, 1, 0, 3);
      check("p32.drops", rdata, STATS ? 32'd3 : 32'd0);
      cyc("p32clr", 0, 0, 0, 0, 1, 1, 2);
      cyc("p32stat2", 0, 0, 0, 0, 1, 0, 1);
      check("p32.status2", rdata, 32'h40000010);
      cyc("p32drops2", 0, 0, 0, 0, 1, 0, 3);
      check("p32.drops2", rdata, 32'h0);

      cyc("p33", 1, 16'hBEEF, 0, 0, 1, 0, 0);
      check("p33.pop", rdata, 32'h80000100);
      cyc("p33stat", 0, 0, 0, 0, 1, 0, 1);
      check("p33.status", rdata, 32'h40000010);

      cyc("p34wr0", 0, 0, 0, 0, 1, 1, 0);
      check("p34.err0", 32'(error), 32'h1);
      cyc("p34off5", 0, 0, 0, 0, 1, 0, 5);
      check("p34.err5", 32'(error), 32'h1);
      cyc("p34idle", 0, 0, 0, 0, 0, 0, 0);
      check("p34.errclr", 32'(error), 32'h0);
      cyc("p34stat", 0, 0, 0, 0, 1, 0, 1);
      check("p34.status", rdata, 32'h40000010);

      for (int i = 0; i < DEPTH; i++) begin
         cyc("drain", 0, 0, 0, 0, 1, 0, 0);
      end

      for (int i = 0; i < 5; i++) begin
         cyc("p35fill", 1, 16'(i), 0, 0, 0, 0, 0);
      end
      cyc("p35stat", 0, 0, 0, 0, 1, 0, 1);
      check("p35.pre", rdata, 32'h20000005 & 32'hDFFFFFFF);
      sel            = 1'b0;
      config_en      = 1'b0;
      data_irq_valid = 1'b1;
      reset_n        = 1'b0;
      #1;
      check("p35.irq", 32'(irq), 32'h0);
      check("p35.rdata", rdata, 32'h0);
      @(posedge clk);
      #1;
      reset_n        = 1'b1;
      data_irq_valid = 1'b0;
      q.delete();
      ovf   = 1'b0;
      drops = 0;
      cyc("p35stat2", 0, 0, 0, 0, 1, 0, 1);
      check("p35.status", rdata, 32'h20000000);

      rnd(1500, 40, 10);
      for (int i = 0; i < 150; i++) begin
         cyc("sat", 1, 16'($urandom), 1, 16'($urandom), 0, 0, 0);
      end
      cyc("satrd", 0, 0, 0, 0, 1, 0, 3);
      check("sat.drops", rdata, STATS ? 32'd255 : 32'd0);
      rnd(1000, 60, 20);
      rnd(600, 10, 60);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/irq_unit_fifo.md
IRQ_UNIT_FIFO -- requirements
Module: irq_unit_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries, power of two, 4..256.
REQ-002 SHALL have parameter CNT_W, default 8, width of the saturating drop counter.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port data_irq_valid / data_irq_addr, input, 1 / 16, data-arrival interrupt push and its payload.
REQ-006 SHALL have port cfg_irq_valid / cfg_irq_addr, input, 1 / 16, configuration interrupt push and its payload.
REQ-007 SHALL have port config_addr, input, 14, config-bus word address; bits [10:0] are the local offset.
REQ-008 SHALL have ports config_en (1), config_wr (1) and config_wdata (32), all inputs, carrying config-bus enable, write strobe and write data.
REQ-009 SHALL have port sel, input, 1, bank select from the config bus.
REQ-010 SHALL have ports rdata (32) and error (1), both outputs, carrying registered read data and access error.
REQ-011 SHALL have port irq, output, 1, high while the FIFO is non-empty.

Function
REQ-012 SHALL treat an access as occurring when sel & config_en are high; rdata and error SHALL update on the edge after the access, which gives 1-cycle latency.
REQ-013 SHALL define entry format {src, addr[15:0]}, where src is 0 for data and 1 for cfg.
REQ-014 SHALL decode offset 0 (read) as POP: non-empty -> rdata = {1, 14'b0, src, addr}, head removed; empty -> rdata = 0, no pop, no error.
REQ-015 SHALL decode offset 1 (read) as STATUS: rdata = {overflow[31], full[30], empty[29], 20'b0, count[8:0]}.
REQ-016 SHALL decode offset 2 (write) as CLEAR: any data clears overflow and the drop counter; a read of offset 2 returns 0.
REQ-017 SHALL decode offset 3 (read) as DROPS: rdata = zero-extended drop counter.
REQ-018 SHALL assert error for one cycle, with rdata = 0 and no state change, on a write to offset 0, 1 or 3, or on any access to an offset above 3.
REQ-019 SHALL hold rdata at 0 and error low in cycles following a non-access.
REQ-020 SHALL order same-cycle pushes as data entry before cfg entry.
REQ-021 SHALL compute free space as DEPTH - count + (pop this cycle ? 1 : 0), so a push on full with a same-cycle pop is accepted.
REQ-022 SHALL drop each push that does not fit, processed in order, set sticky overflow, and increment the drop counter, saturating at all-ones; two drops in one cycle add 2, saturating.
REQ-023 SHALL let CLEAR win over a same-cycle drop: the flag and counter end at 0.
REQ-024 SHALL keep count in 0..DEPTH, with read/write pointers wrapping modulo DEPTH.
REQ-025 SHALL drive irq combinationally from count != 0.

Reset
REQ-026 SHALL, while reset_n is low, immediately force count, pointers, overflow, drop counter, rdata and error to 0, and irq low.
REQ-027 SHALL, on reset_n assertion mid-operation, lose queued entries and accept no push until reset_n is high.

Configuration
REQ-028 SHALL compile in, under macro IRQ_UNIT_FIFO_STATS_EN, the drop counter and offset 3.
REQ-029 SHALL, without IRQ_UNIT_FIFO_STATS_EN, omit the counter: offset 3 reads 0 without error, CLEAR clears overflow only, and the overflow flag is still present.

Verification
REQ-030 SHALL cover: push data 0x00A5 -> irq=1; POP -> next-cycle rdata=0x800000A5, irq=0; second POP -> rdata=0, error=0.
REQ-031 SHALL cover: same-cycle data 0x0001 and cfg 0x0002 -> POPs return 0x80000001, then 0x80010002.
REQ-032 SHALL cover: fill 16, push 3 more -> STATUS=0xC0000010, DROPS=3; CLEAR -> STATUS=0x40000010, DROPS=0.
REQ-033 SHALL cover: full FIFO with POP plus data push in the same cycle -> push accepted, count stays 16, overflow=0.
REQ-034 SHALL cover: write offset 0, and access offset 5 -> error=1 for one cycle each, count unchanged.
REQ-035 SHALL cover: reset_n low for 1 cycle with 5 entries -> irq=0 immediately, STATUS=0x20000000 after release.
